wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/wb_arb_timeout.sv | 43 ++++
 rtl/wb_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared constants for the two-master Wishbone memory arbiter:
//                FSM state encodings and wait-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    // Width of the slave-ack wait counter (TIMEOUT must fit in it)
    localparam int unsigned c_WAIT_CNT_W = 8;

    typedef logic [c_WAIT_CNT_W-1:0] wait_cnt_t;

    // Arbiter FSM state encodings
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_timeout
//  Description : Counts cycles a granted strobe waits for slave ack and
//                raises a one-cycle error pulse when the wait hits TIMEOUT.
//                An ack in the same cycle as the limit suppresses the error.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_idle,     // arbiter has no grant
    input  logic i_active,   // granted master has cyc & stb high
    input  logic i_ack,      // slave ack
    output logic o_err       // timeout pulse for the granted master
);

    localparam wait_cnt_t c_TIMEOUT = wait_cnt_t'(TIMEOUT);

    wait_cnt_t r_count;
    logic      w_hit;

    // Limit reached on a live strobe with no ack arriving this cycle
    assign w_hit = i_active && (r_count == c_TIMEOUT) && !i_ack;
    assign o_err = w_hit;

    // Wait counter: restarts on idle, ack, dropped strobe or a fired timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_idle || i_ack || !i_active || w_hit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : wb_arb_timeout
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_arbiter
//  Description : Round-robin arbiter giving two Wishbone masters access to one
//                shared memory slave. Grant is held for the whole cyc_i
//                assertion; slave-side signals are a combinational mux of the
//                granted master. A stalled strobe is errored after TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    // master 0
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    // master 1
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    // shared slave
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;     // 0: master 0 last granted, 1: master 1
    logic       w_next_last_grant;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_active;
    logic       w_timeout_err;

    assign w_gnt0 = (r_state == c_GNT0);
    assign w_gnt1 = (r_state == c_GNT1);

    // Granted master is presenting a live strobe this cycle
    assign w_active = (w_gnt0 && m0_cyc_i && m0_stb_i) ||
                      (w_gnt1 && m1_cyc_i && m1_stb_i);

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst_n    (wb_rstn_i),
        .i_idle   (r_state == c_IDLE),
        .i_active (w_active),
        .i_ack    (s_ack_i),
        .o_err    (w_timeout_err)
    );

    // Next grant: round-robin on contention, hold until owner drops cyc
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            c_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (r_last_grant) begin
                        w_next_state      = c_GNT0;
                        w_next_last_grant = 1'b0;
                    end else begin
                        w_next_state      = c_GNT1;
                        w_next_last_grant = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    w_next_state      = c_GNT0;
                    w_next_last_grant = 1'b0;
                end else if (m1_cyc_i) begin
                    w_next_state      = c_GNT1;
                    w_next_last_grant = 1'b1;
                end
            end
            c_GNT0: begin
                if (!m0_cyc_i) begin
                    w_next_state = c_IDLE;
                end
            end
            c_GNT1: begin
                if (!m1_cyc_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // State and round-robin history; reset favours master 0 first
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Slave-side mux and per-master ack/err routing
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_gnt0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i && !w_timeout_err;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            m0_ack_o = s_ack_i;
            m0_err_o = w_timeout_err;
        end else if (w_gnt1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i && !w_timeout_err;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            m1_ack_o = s_ack_i;
            m1_err_o = w_timeout_err;
        end
    end

    // Read data is a shared bus; each master qualifies it with its own ack
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule : wb_mem_arbiter
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_mem_arbiter
//  Description : Self-checking bench for wb_mem_arbiter: directed table,
//                timeout / async-reset sequences and random traffic against
//                a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arbiter;

    localparam int TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rstn_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    wb_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .wb_clk_i (wb_clk_i), .wb_rstn_i(wb_rstn_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o  (s_we_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o (s_sel_o),
        .s_ack_i  (s_ack_i),  .s_dat_i  (s_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        scyc, sstb, swe;
        logic [31:0] sadr, sdat;
        logic [3:0]  ssel;
        logic        a0, e0, a1, e1;
        logic [31:0] d0, d1;
    } out_t;

    typedef struct packed {
        logic        c0, s0, c1, s1, ack;
        logic [31:0] adr1;
        logic [1:0]  g;        // expected mirror: 0 none, 1 master0, 2 master1
        logic        scyc, sstb, a0, a1;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int m_owner;   // -1 none, else granted master index
    int m_last;    // master granted most recently
    int m_wcnt;    // cycles the current strobe has waited

    function automatic out_t dut_out();
        out_t o;
        o.scyc = s_cyc_o;  o.sstb = s_stb_o;  o.swe = s_we_o;
        o.sadr = s_adr_o;  o.sdat = s_dat_o;  o.ssel = s_sel_o;
        o.a0 = m0_ack_o;   o.e0 = m0_err_o;
        o.a1 = m1_ack_o;   o.e1 = m1_err_o;
        o.d0 = m0_dat_o;   o.d1 = m1_dat_o;
        return o;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_ack_i = 0;  s_dat_i = '0;
    endtask

    task automatic do_reset();
        wb_rstn_i = 0;
        idle_inputs();
        tick();
        tick();
        wb_rstn_i = 1;
        m_owner = -1; m_last = 1; m_wcnt = 0;
    endtask

    // Expected outputs from the arbitration rules and current inputs
    function automatic out_t model_out();
        out_t e;
        logic gc, gs, to;
        e = '0;
        e.d0 = s_dat_i;
        e.d1 = s_dat_i;
        if (m_owner >= 0) begin
            gc = (m_owner == 0) ? m0_cyc_i : m1_cyc_i;
            gs = (m_owner == 0) ? m0_stb_i : m1_stb_i;
            to = gc && gs && (m_wcnt == TMO) && !s_ack_i;
            e.scyc = gc;
            e.sstb = gs && !to;
            e.swe  = (m_owner == 0) ? m0_we_i  : m1_we_i;
            e.sadr = (m_owner == 0) ? m0_adr_i : m1_adr_i;
            e.sdat = (m_owner == 0) ? m0_dat_i : m1_dat_i;
            e.ssel = (m_owner == 0) ? m0_sel_i : m1_sel_i;
            if (m_owner == 0) begin e.a0 = s_ack_i; e.e0 = to; end
            else              begin e.a1 = s_ack_i; e.e1 = to; end
        end
        return e;
    endfunction

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_step();
        logic gc, gs;
        if (m_owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) m_owner = 1 - m_last;
            else if (m0_cyc_i)        m_owner = 0;
            else if (m1_cyc_i)        m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
            m_wcnt = 0;
        end else begin
            gc = (m_owner == 0) ? m0_cyc_i : m1_cyc_i;
            gs = (m_owner == 0) ? m0_stb_i : m1_stb_i;
            if (!gc) begin
                m_owner = -1;
                m_wcnt  = 0;
            end else if (s_ack_i || !gs || m_wcnt == TMO) begin
                m_wcnt = 0;
            end else begin
                m_wcnt = m_wcnt + 1;
            end
        end
    endtask

    vec_t tbl [14];

    initial begin
        out_t e;

        tbl[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 32'h0, 2'd0, 1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h0, 2'd1, 1'b1,1'b1,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0, 2'd1, 1'b0,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 32'h0, 2'd0, 1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h0, 2'd2, 1'b1,1'b1,1'b0,1'b1};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 32'h4, 2'd2, 1'b1,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h4, 2'd2, 1'b1,1'b1,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h8, 2'd2, 1'b1,1'b1,1'b0,1'b1};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h8, 2'd2, 1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h8, 2'd0, 1'b0,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 32'h8, 2'd1, 1'b1,1'b1,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h8, 2'd1, 1'b0,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h8, 2'd0, 1'b0,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 32'hC, 2'd2, 1'b1,1'b1,1'b0,1'b1};

        // ---------------- reset state ----------------
        wb_rstn_i = 0;
        idle_inputs();
        @(negedge wb_clk_i);
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        s_ack_i = 1;  s_dat_i = 32'hA5A5_0F0F;
        #1;
        e = '0; e.d0 = 32'hA5A5_0F0F; e.d1 = 32'hA5A5_0F0F;
        check("reset_outputs", 160'(dut_out()), 160'(e));

        // ---------------- directed table ----------------
        do_reset();
        m0_we_i = 1; m0_adr_i = 32'h0000_0010; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
        m1_we_i = 0; m1_dat_i = 32'h1111_0000; m1_sel_i = 4'hF;
        for (int i = 0; i < 14; i++) begin
            m0_cyc_i = tbl[i].c0; m0_stb_i = tbl[i].s0;
            m1_cyc_i = tbl[i].c1; m1_stb_i = tbl[i].s1;
            m1_adr_i = tbl[i].adr1;
            s_ack_i  = tbl[i].ack;
            s_dat_i  = $urandom;
            #1;
            e = '0;
            if (tbl[i].g == 2'd1) begin
                e.swe = 1; e.sadr = 32'h10; e.sdat = 32'hDEAD_BEEF; e.ssel = 4'hF;
            end else if (tbl[i].g == 2'd2) begin
                e.swe = 0; e.sadr = tbl[i].adr1; e.sdat = 32'h1111_0000; e.ssel = 4'hF;
            end
            e.scyc = tbl[i].scyc; e.sstb = tbl[i].sstb;
            e.a0 = tbl[i].a0; e.a1 = tbl[i].a1;
            e.d0 = s_dat_i; e.d1 = s_dat_i;
            check($sformatf("table[%0d]", i), 160'(dut_out()), 160'(e));
            tick();
        end

        // ---------------- timeout, slave silent ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h20;
        tick();
        for (int k = 0; k <= 20; k++) begin
            #1;
            check($sformatf("timeout_k%0d", k),
                  160'({s_stb_o, m0_ack_o, m0_err_o, m1_err_o}),
                  160'({k != 16, 1'b0, k == 16, 1'b0}));
            tick();
        end

        // ---------------- ack coincides with timeout ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h24;
        tick();
        for (int k = 0; k <= 20; k++) begin
            s_ack_i = (k == 16);
            #1;
            check($sformatf("ack_vs_timeout_k%0d", k),
                  160'({s_stb_o, m0_ack_o, m0_err_o, m1_ack_o}),
                  160'({1'b1, k == 16, 1'b0, 1'b0}));
            tick();
        end

        // ---------------- async reset mid GNT1 ----------------
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h40;
        tick();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        #1;
        check("gnt1_before_reset", 160'({s_cyc_o, m1_ack_o, s_adr_o}), 160'({1'b1, 1'b1, 32'h40}));
        #2;
        wb_rstn_i = 0;
        #1;
        check("async_reset_drop",
              160'({s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o, m1_dat_o}),
              160'({1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678}));
        tick();
        wb_rstn_i = 1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        #1;
        check("post_reset_idle", 160'({s_cyc_o, m0_ack_o, m1_ack_o}), 160'({1'b0, 1'b0, 1'b0}));
        tick();
        #1;
        check("post_reset_gnt0",
              160'({s_cyc_o, s_adr_o, m0_ack_o, m1_ack_o}),
              160'({1'b1, 32'h10, 1'b1, 1'b0}));
        tick();

        // ---------------- random traffic vs model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m0_cyc_i) begin
                if ($urandom_range(31) == 0) m0_cyc_i = 0;
            end else if ($urandom_range(3) == 0) begin
                m0_cyc_i = 1;
            end
            if (m1_cyc_i) begin
                if ($urandom_range(31) == 0) m1_cyc_i = 0;
            end else if ($urandom_range(3) == 0) begin
                m1_cyc_i = 1;
            end
            m0_stb_i = m0_cyc_i && ($urandom_range(15) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(15) != 0);
            m0_we_i  = 1'($urandom); m1_we_i = 1'($urandom);
            m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom);
            m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom);
            s_ack_i  = ($urandom_range(15) == 0);
            s_dat_i  = $urandom;
            #1;
            check($sformatf("random[%0d]", c), 160'(dut_out()), 160'(model_out()));
            model_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_wb_mem_arbiter
`default_nettype wire
